count_capture: RTL
==================

COUNT_CAPTURE -- requirements
Module: count_capture

Interface
REQ-001 Parameter: W, 24, width of captured count.
REQ-002 Parameter: DEPTH, 4, capture FIFO entries; power of two, at least 2.
REQ-003 Port: clk  input  1  single clock; all state on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: count_in  input  W  free-running count from the 24-bit counter stage, synchronous to clk.
REQ-006 Port: evt_in  input  1  asynchronous external event line.
REQ-007 Port: edge_sel  input  2  00 disabled, 01 rising, 10 falling, 11 both edges.
REQ-008 Port: cap_data  output  W  oldest captured count (FIFO head).
REQ-009 Port: cap_valid  output  1  FIFO not empty.
REQ-010 Port: cap_ready  input  1  consumer accepts head.
REQ-011 Port: level  output  clog2(DEPTH)+1  number of entries held.
REQ-012 Port: ovf  output  1  sticky: a capture was dropped.
REQ-013 Port: ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-014 evt_in SHALL pass through a 2-flop synchronizer, then one history flop; the edge is detected from the last two synchronized samples.
REQ-015 Detected edge SHALL be qualified by edge_sel as sampled in the same cycle; 00 suppresses all captures; history flops keep tracking in every mode.
REQ-016 On a qualified edge, the count_in value present in that same cycle SHALL be pushed; a clean evt_in transition set up before clock edge k yields a push at edge k+3.
REQ-017 FIFO SHALL be first-word-fall-through: cap_data SHALL equal the head whenever cap_valid=1; cap_data is don't-care when cap_valid=0.
REQ-018 Pop SHALL occur on a cycle with cap_valid=1 and cap_ready=1; cap_ready with cap_valid=0 has no effect.
REQ-019 cap_data SHALL hold stable while cap_valid=1 and cap_ready=0.
REQ-020 Push when level<DEPTH: accepted; level+1 unless a pop occurs the same cycle (level unchanged).
REQ-021 Push when level=DEPTH with a pop the same cycle: accepted, level stays DEPTH, ovf unchanged.
REQ-022 Push when level=DEPTH without a pop: data dropped, FIFO contents unchanged, ovf set next cycle.
REQ-023 Push when level=0: cap_valid rises the next cycle; no same-cycle bypass.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by level, never by pointer equality alone.
REQ-025 ovf_clr=1 SHALL clear ovf next cycle; if a drop occurs the same cycle, set wins.
REQ-026 Capture of count_in SHALL be raw and unsigned; count wrap-around (FFFFFF to 000000) needs no special handling.

Reset
REQ-027 reset low SHALL asynchronously force: level=0, cap_valid=0, ovf=0, pointers=0, all synchronizer and history flops=0.
REQ-028 Reset asserted mid-operation SHALL discard all stored captures; cap_data may hold stale storage, masked by cap_valid=0.
REQ-029 Release SHALL be synchronous to clk; if evt_in is high at release, edge_sel=01 or 11 yields one capture once the synchronizer fills.
REQ-030 FIFO storage array needs no reset.

Verification
REQ-031 edge_sel=01, count_in ramping, evt_in rises once before edge k -> one entry equal to count_in at edge k+3; level=1; cap_valid=1.
REQ-032 edge_sel=11, evt_in pulse high for 5 cycles -> two entries 5 apart in count value; edge_sel=00 with the same pulse -> no entries.
REQ-033 cap_ready=0, five rising edges -> level=4, entries 1-4 retained, ovf=1; ovf_clr pulse -> ovf=0; clear with a simultaneous drop -> ovf stays 1.
REQ-034 Full FIFO, cap_ready=1 in the same cycle as a qualified edge -> oldest entry popped, new entry accepted, level=4, ovf=0.
REQ-035 Drain across pointer wrap (push 3, pop 3, push 4, pop 4) -> data emerges in push order, level returns to 0.
REQ-036 reset asserted with level=3 and ovf=1 -> level=0, cap_valid=0, ovf=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/count_capture.sv
// count_capture: timestamps edges of an asynchronous event line.
// The event is synchronized, edge-detected, qualified by edge_sel and the
// free-running count_in value is pushed into a small first-word-fall-through
// FIFO. A sticky ovf flag records any capture lost to a full FIFO.
module count_capture #(
  parameter int unsigned W     = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [W-1:0]             count_in,
  input  logic                     evt_in,
  input  logic [1:0]               edge_sel,
  output logic [W-1:0]             cap_data,
  output logic                     cap_valid,
  input  logic                     cap_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FullLevel = LW'(DEPTH);

  typedef enum logic [1:0] {
    SelOff  = 2'b00,
    SelRise = 2'b01,
    SelFall = 2'b10,
    SelBoth = 2'b11
  } edge_sel_e;

  // ---------------------------------------------------------------------------
  // Event synchronizer and edge detection
  // ---------------------------------------------------------------------------
  logic meta_q;   // first synchronizer stage, may go metastable
  logic sync_q;   // second synchronizer stage, safe to use
  logic hist_q;   // previous synchronized sample
  logic rise_q;   // registered rising edge of the synchronized event
  logic fall_q;   // registered falling edge of the synchronized event

  logic rise_d;
  logic fall_d;

  // Raw edges from the two most recent synchronized samples.
  always_comb begin
    rise_d = sync_q & ~hist_q;
    fall_d = ~sync_q & hist_q;
  end

  // Synchronizer, history and edge registers; they track evt_in in every mode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= evt_in;
      sync_q <= meta_q;
      hist_q <= sync_q;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Edge qualification
  // ---------------------------------------------------------------------------
  logic push;

  // edge_sel is applied in the same cycle as the push so the pushed count and
  // the selection that allowed it always belong together.
  always_comb begin
    push = 1'b0;
    case (edge_sel_e'(edge_sel))
      SelOff:  push = 1'b0;
      SelRise: push = rise_q;
      SelFall: push = fall_q;
      SelBoth: push = rise_q | fall_q;
      default: push = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Capture FIFO
  // ---------------------------------------------------------------------------
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;

  logic empty;
  logic full;
  logic pop;
  logic push_accept;
  logic drop;

  // Handshake decode; full/empty come from the level counter only, since the
  // pointers are equal in both cases.
  always_comb begin
    empty       = (level_q == '0);
    full        = (level_q == FullLevel);
    pop         = ~empty & cap_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    push_accept = push & (~full | pop);
    drop        = push & full & ~pop;
  end

  // Next-state for pointers, level and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;

    // Power-of-two depth: plain increment wraps modulo DEPTH.
    if (push_accept) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    if (push_accept && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push_accept) begin
      level_d = level_q - LW'(1);
    end

    // Set has priority so a drop is never hidden by a coincident clear.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // FIFO control state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; contents are only meaningful under cap_valid, so no reset.
  always_ff @(posedge clk) begin
    if (push_accept) begin
      mem_q[wr_ptr_q] <= count_in;
    end
  end

  // Fall-through outputs: head is visible as soon as the entry is written.
  always_comb begin
    cap_data  = mem_q[rd_ptr_q];
    cap_valid = ~empty;
    level     = level_q;
    ovf       = ovf_q;
  end

endmodule
